// File: rtl/uart_rx_hex_pkg.sv
// Shared definitions for the HEX-loader UART receiver: FSM encoding, parity modes,
// oversampling constants and the parity check helper.
package uart_rx_hex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int         OVS    = 16;
  localparam logic [3:0] SC_MID = 4'd7;

  // x is the XOR of the eight data bits and the received parity bit.
  function automatic logic parity_ok(input int mode, input logic x);
    return (mode == PAR_ODD) ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_rx_hex_baud.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
// sync_clr holds the counter at zero so the tick phase follows the start edge.
module uart_rx_hex_baud #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic clr,
  input  logic sync_clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (sync_clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST) && !sync_clr;

endmodule

// File: rtl/uart_rx_hex.sv
// UART receiver feeding the HEX converter: 16x oversampled 8-bit frames, optional parity,
// one-clock dv/ferr/perr strobes; errored bytes never reach dout.
module uart_rx_hex
  import uart_rx_hex_pkg::*;
#(
  parameter int DIV    = 27,
  parameter int PARITY = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dv,
  output logic       ferr,
  output logic       perr,
  output logic       busy,
  output state_t     dbg_state
);

  // Handshake: dv is a single-clock valid with no ready; dout is stable from the dv
  // clock until the next dv, so the sink must capture it while dv is high.

  logic       rx_meta, rxs;
  logic       tick, sample;
  state_t     state;
  logic [3:0] sc;
  logic [2:0] bitn;
  logic [7:0] shreg;
  logic       par_acc, perr_l;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  uart_rx_hex_baud #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .clr      (clr),
    .sync_clr (state == ST_IDLE),
    .tick     (tick)
  );

  // Act on the tick that moves sc onto mid, i.e. the first instant sc==7 holds.
  assign sample = tick && (sc == SC_MID - 4'd1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      sc      <= '0;
      bitn    <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      perr_l  <= 1'b0;
      dout    <= '0;
      dv      <= 1'b0;
      ferr    <= 1'b0;
      perr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      dv   <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
      if (tick) sc <= sc + 4'd1;
      case (state)
        ST_IDLE: begin
          sc   <= '0;
          busy <= 1'b0;
          if (!rxs) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (sample) begin
            if (rxs) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bitn    <= '0;
              par_acc <= 1'b0;
              perr_l  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            shreg   <= {rxs, shreg[7:1]};
            par_acc <= par_acc ^ rxs;
            bitn    <= bitn + 3'd1;
            if (bitn == 3'd7) state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (sample) begin
            perr_l <= !parity_ok(PARITY, par_acc ^ rxs);
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at stop mid so a start bit with zero idle gap is still seen.
          if (sample) begin
            if (!rxs) begin
              ferr  <= 1'b1;
              state <= ST_BRK;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              if (perr_l) begin
                perr <= 1'b1;
              end else begin
                dout <= shreg;
                dv   <= 1'b1;
              end
            end
          end
        end
        ST_BRK: begin
          if (rxs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_hex.sv
// Bench for uart_rx_hex: three instances (no, even, odd parity) driven with directed
// and random frames, checked against a frame-level outcome model.
module tb_uart_rx_hex;
  import uart_rx_hex_pkg::*;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       clr = 1'b0;
  logic [2:0] rxd = 3'b111;
  logic [7:0] dout [3];
  logic [2:0] dv, ferr, perr, busy;
  state_t     st [3];

  uart_rx_hex #(.DIV(DIV), .PARITY(0)) dut0 (.clk(clk), .clr(clr), .rxd(rxd[0]), .dout(dout[0]),
    .dv(dv[0]), .ferr(ferr[0]), .perr(perr[0]), .busy(busy[0]), .dbg_state(st[0]));
  uart_rx_hex #(.DIV(DIV), .PARITY(1)) dut1 (.clk(clk), .clr(clr), .rxd(rxd[1]), .dout(dout[1]),
    .dv(dv[1]), .ferr(ferr[1]), .perr(perr[1]), .busy(busy[1]), .dbg_state(st[1]));
  uart_rx_hex #(.DIV(DIV), .PARITY(2)) dut2 (.clk(clk), .clr(clr), .rxd(rxd[2]), .dout(dout[2]),
    .dv(dv[2]), .ferr(ferr[2]), .perr(perr[2]), .busy(busy[2]), .dbg_state(st[2]));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [7:0] got_q0[$], got_q1[$], got_q2[$];
  int         dv_cyc_q[$];
  int         dv_n [3] = '{0, 0, 0};
  int         ferr_n [3] = '{0, 0, 0};
  int         perr_n [3] = '{0, 0, 0};
  int         viol_n = 0;
  logic [2:0] dv_d = '0, ferr_d = '0, perr_d = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i]) dv_n[i]++;
      if (ferr[i]) ferr_n[i]++;
      if (perr[i]) perr_n[i]++;
      if ((dv[i] & dv_d[i]) | (ferr[i] & ferr_d[i]) | (perr[i] & perr_d[i])) viol_n++;
      if (32'(dv[i]) + 32'(ferr[i]) + 32'(perr[i]) > 1) viol_n++;
    end
    if (dv[0]) begin got_q0.push_back(dout[0]); dv_cyc_q.push_back(cyc); end
    if (dv[1]) got_q1.push_back(dout[1]);
    if (dv[2]) got_q2.push_back(dout[2]);
    dv_d   = dv;
    ferr_d = ferr;
    perr_d = perr;
  end

  // ---------------- reference model ----------------
  // Parity bit a correct transmitter sends: even makes the 9-bit XOR 0, odd makes it 1.
  function automatic logic good_par(input int ch, input logic [7:0] b);
    return (ch == 1) ? ^b : ~^b;
  endfunction

  // ---------------- drivers ----------------
  task automatic hold(input int ch, input logic v, input int n);
    rxd[ch] = v;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int ch, input logic [7:0] b, input bit use_par,
                            input logic pbit, input logic stopb, input int stop_clks);
    hold(ch, 1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(ch, b[i], BIT);
    if (use_par) hold(ch, pbit, BIT);
    hold(ch, stopb, stop_clks);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(3);
    tests++;
    if ({dout[0], dout[1], dout[2], dv, ferr, perr, busy} !== 36'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h %h %h dv=%b ferr=%b perr=%b busy=%b, expected all 0",
               dout[0], dout[1], dout[2], dv, ferr, perr, busy);
    end
    tests++;
    if (st[0] !== ST_IDLE || st[1] !== ST_IDLE || st[2] !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d %0d %0d, expected IDLE", st[0], st[1], st[2]);
    end
    clr = 1'b1;
    idle(10);
  endtask

  task automatic test_single();
    int bf, bp;
    got_q0.delete();
    bf = ferr_n[0]; bp = perr_n[0];
    send_frame(0, 8'h3A, 1'b0, 1'b0, 1'b1, BIT);
    idle(10);
    tests++;
    if (got_q0.size() !== 1) begin
      fails++; $display("FAIL single_dv_count: got %0d, expected 1", got_q0.size());
    end
    tests++;
    if (dout[0] !== 8'h3A) begin
      fails++; $display("FAIL single_dout: got %h, expected 3a", dout[0]);
    end
    tests++;
    if (ferr_n[0] - bf != 0 || perr_n[0] - bp != 0) begin
      fails++; $display("FAIL single_err: ferr %0d perr %0d, expected 0 0", ferr_n[0] - bf, perr_n[0] - bp);
    end
    tests++;
    if (busy[0] !== 1'b0) begin
      fails++; $display("FAIL single_busy: got %b, expected 0", busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    got_q0.delete();
    dv_cyc_q.delete();
    send_frame(0, 8'h3A, 1'b0, 1'b0, 1'b1, BIT);
    send_frame(0, 8'h30, 1'b0, 1'b0, 1'b1, BIT);
    idle(10);
    tests++;
    if (got_q0.size() !== 2) begin
      fails++; $display("FAIL b2b_count: got %0d, expected 2", got_q0.size());
    end else begin
      tests++;
      if (got_q0[0] !== 8'h3A || got_q0[1] !== 8'h30) begin
        fails++; $display("FAIL b2b_data: got %h %h, expected 3a 30", got_q0[0], got_q0[1]);
      end
      tests++;
      if (dv_cyc_q[1] - dv_cyc_q[0] != 10 * BIT) begin
        fails++; $display("FAIL b2b_spacing: got %0d, expected %0d", dv_cyc_q[1] - dv_cyc_q[0], 10 * BIT);
      end
    end
  endtask

  task automatic test_glitch();
    int bd, bf, start;
    bd = dv_n[0]; bf = ferr_n[0];
    start = cyc;
    hold(0, 1'b0, 10);
    tests++;
    if (busy[0] !== 1'b1) begin
      fails++; $display("FAIL glitch_busy_rise: got %b, expected 1", busy[0]);
    end
    hold(0, 1'b0, 10);
    rxd[0] = 1'b1;
    while (busy[0] && (cyc - start) < 48) begin
      @(posedge clk); #1;
    end
    tests++;
    if (busy[0] !== 1'b0 || (cyc - start) > 32) begin
      fails++; $display("FAIL glitch_busy_fall: busy %b after %0d clocks, expected 0 within 32", busy[0], cyc - start);
    end
    idle(2 * BIT);
    tests++;
    if (dv_n[0] != bd || ferr_n[0] != bf) begin
      fails++; $display("FAIL glitch_strobes: dv %0d ferr %0d, expected 0 0", dv_n[0] - bd, ferr_n[0] - bf);
    end
  endtask

  task automatic test_framing();
    int bd, bf;
    bd = dv_n[0]; bf = ferr_n[0];
    send_frame(0, 8'h41, 1'b0, 1'b0, 1'b0, 200);
    tests++;
    if (ferr_n[0] - bf != 1 || dv_n[0] != bd) begin
      fails++; $display("FAIL ferr_strobes: ferr %0d dv %0d, expected 1 0", ferr_n[0] - bf, dv_n[0] - bd);
    end
    tests++;
    if (dout[0] !== 8'h30) begin
      fails++; $display("FAIL ferr_dout: got %h, expected 30", dout[0]);
    end
    tests++;
    if (busy[0] !== 1'b1 || st[0] !== ST_BRK) begin
      fails++; $display("FAIL ferr_break: busy %b state %0d, expected 1 BRK", busy[0], st[0]);
    end
    hold(0, 1'b1, 5);
    tests++;
    if (busy[0] !== 1'b0) begin
      fails++; $display("FAIL ferr_release: busy %b, expected 0", busy[0]);
    end
  endtask

  task automatic test_parity();
    int bd, bp;
    bd = dv_n[1]; bp = perr_n[1];
    send_frame(1, 8'h31, 1'b1, 1'b0, 1'b1, BIT);
    idle(10);
    tests++;
    if (perr_n[1] - bp != 1 || dv_n[1] != bd) begin
      fails++; $display("FAIL perr_bad: perr %0d dv %0d, expected 1 0", perr_n[1] - bp, dv_n[1] - bd);
    end
    send_frame(1, 8'h31, 1'b1, 1'b1, 1'b1, BIT);
    idle(10);
    tests++;
    if (dv_n[1] - bd != 1 || perr_n[1] - bp != 1 || dout[1] !== 8'h31) begin
      fails++; $display("FAIL perr_good: dv %0d perr %0d dout %h, expected 1 1 31",
                        dv_n[1] - bd, perr_n[1] - bp, dout[1]);
    end
  endtask

  task automatic test_reset_midframe();
    int bd, bf;
    logic [7:0] b;
    b = 8'h0D;
    bd = dv_n[0]; bf = ferr_n[0] + perr_n[0];
    hold(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(0, b[i], BIT);
    hold(0, b[4], 30);
    clr = 1'b0;
    #1;
    tests++;
    if ({dout[0], dv[0], ferr[0], perr[0], busy[0]} !== 12'h0 || st[0] !== ST_IDLE) begin
      fails++; $display("FAIL midreset_outputs: dout %h dv %b ferr %b perr %b busy %b state %0d, expected 0",
                        dout[0], dv[0], ferr[0], perr[0], busy[0], st[0]);
    end
    rxd[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    idle(20);
    send_frame(0, 8'h0D, 1'b0, 1'b0, 1'b1, BIT);
    idle(10);
    tests++;
    if (dv_n[0] - bd != 1 || dout[0] !== 8'h0D || ferr_n[0] + perr_n[0] != bf) begin
      fails++; $display("FAIL midreset_next: dv %0d dout %h errs %0d, expected 1 0d 0",
                        dv_n[0] - bd, dout[0], ferr_n[0] + perr_n[0] - bf);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [7:0] b;
    int kind, exp_f, exp_p, bf, bp;
    for (int ch = 0; ch < 3; ch++) begin
      exp_q.delete();
      case (ch)
        0: got_q0.delete();
        1: got_q1.delete();
        default: got_q2.delete();
      endcase
      exp_f = 0; exp_p = 0;
      bf = ferr_n[ch]; bp = perr_n[ch];
      for (int n = 0; n < 10; n++) begin
        b    = 8'($urandom_range(0, 255));
        kind = $urandom_range(0, 3);
        if (kind == 0) begin
          send_frame(ch, b, ch != 0, good_par(ch, b), 1'b0, BIT);
          hold(ch, 1'b1, $urandom_range(4, 40));
          exp_f++;
        end else if (kind == 1 && ch != 0) begin
          send_frame(ch, b, 1'b1, ~good_par(ch, b), 1'b1, BIT);
          hold(ch, 1'b1, $urandom_range(0, 30));
          exp_p++;
        end else begin
          send_frame(ch, b, ch != 0, good_par(ch, b), 1'b1, BIT);
          hold(ch, 1'b1, $urandom_range(0, 30));
          exp_q.push_back(b);
        end
      end
      idle(20);
      case (ch)
        0: got = got_q0;
        1: got = got_q1;
        default: got = got_q2;
      endcase
      tests++;
      if (got.size() != exp_q.size()) begin
        fails++; $display("FAIL rand_count ch%0d: got %0d, expected %0d", ch, got.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          tests++;
          if (got[k] !== exp_q[k]) begin
            fails++; $display("FAIL rand_data ch%0d[%0d]: got %h, expected %h", ch, k, got[k], exp_q[k]);
          end
        end
      end
      tests++;
      if (ferr_n[ch] - bf != exp_f || perr_n[ch] - bp != exp_p) begin
        fails++; $display("FAIL rand_errs ch%0d: ferr %0d perr %0d, expected %0d %0d",
                          ch, ferr_n[ch] - bf, perr_n[ch] - bp, exp_f, exp_p);
      end
    end
  endtask

  task automatic test_strobe_shape();
    tests++;
    if (viol_n != 0) begin
      fails++; $display("FAIL strobe_shape: %0d overlapping or stretched strobes, expected 0", viol_n);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_parity();
    test_reset_midframe();
    test_random();
    test_strobe_shape();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
